// File: rtl/transmission8_sched_if.sv
// ---------------------------------------------------------------------------
// transmission8_sched_if
// Groups the request/grant signals shared by the eight sources and the
// round-robin scheduler that drives the transmission8 selector.
//   iReq   [7:0] : per-channel request, bit i requests channel i
//   iEn          : global enable for new grants and current tenure
//   A, B, C      : selector index to transmission8 (A = MSB)
//   oGrant [7:0] : one-hot grant, zero when nobody owns the path
//   oBusy        : high while a tenure is active
//   oCount [3:0] : cycles elapsed in the current tenure, 0 outside it
// master = request side (sources), slave = scheduler side.
// ---------------------------------------------------------------------------
interface transmission8_sched_if;
  logic [7:0] iReq;
  logic       iEn;
  logic       A;
  logic       B;
  logic       C;
  logic [7:0] oGrant;
  logic       oBusy;
  logic [3:0] oCount;

  modport master (
    output iReq, iEn,
    input  A, B, C, oGrant, oBusy, oCount
  );

  modport slave (
    input  iReq, iEn,
    output A, B, C, oGrant, oBusy, oCount
  );
endinterface

// File: rtl/transmission8_sched.sv
// ---------------------------------------------------------------------------
// transmission8_sched
// Round-robin scheduler sharing the 8-channel transmission8 selector between
// eight sources. One owner at a time, tenure bounded by HOLD_MAX cycles, and
// a mandatory one-cycle gap between tenures so the selector never switches
// while a source still believes it owns the path.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : transmission8_sched_if.slave (iReq, iEn in; A/B/C, oGrant,
//          oBusy, oCount out -- all outputs registered)
// Parameter:
//   HOLD_MAX : maximum tenure in cycles, 1..15
// ---------------------------------------------------------------------------
module transmission8_sched #(
  parameter int HOLD_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  transmission8_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state_q, state_d;
  logic [7:0] grant_q, grant_d;
  logic [2:0] sel_q,   sel_d;
  logic       busy_q,  busy_d;
  logic [3:0] count_q, count_d;
  logic [2:0] last_q,  last_d;

  // Round-robin search starting at last_q+1; the offset of 8 wraps back to
  // last_q itself, so a sole requester can be regranted.
  logic [2:0] winner;
  logic       found;
  logic [2:0] idx;

  always_comb begin
    winner = last_q;
    found  = 1'b0;
    idx    = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last_q + 3'(k);
      if (!found && bus.iReq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  wire start_ok = bus.iEn && (bus.iReq != 8'h00);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    count_d = count_q;
    last_d  = last_q;

    case (state_q)
      IDLE, GAP: begin
        // Both states behave alike at the edge: grant if possible, otherwise
        // settle in IDLE with the select lines left where they were.
        grant_d = 8'h00;
        busy_d  = 1'b0;
        count_d = 4'd0;
        state_d = IDLE;
        if (start_ok) begin
          state_d = GRANT;
          grant_d = 8'h01 << winner;
          sel_d   = winner;
          busy_d  = 1'b1;
          count_d = 4'd1;
          last_d  = winner;
        end
      end

      GRANT: begin
        // Other requesters never pre-empt; only the owner, iEn or the
        // tenure limit can end the grant.
        if (!bus.iReq[sel_q] || !bus.iEn || (count_q >= HOLD_LIM)) begin
          state_d = GAP;
          grant_d = 8'h00;
          busy_d  = 1'b0;
          count_d = 4'd0;
        end else begin
          count_d = count_q + 4'd1;
        end
      end

      default: begin
        // Illegal encoding: recover exactly as from reset.
        state_d = IDLE;
        grant_d = 8'h00;
        sel_d   = 3'd0;
        busy_d  = 1'b0;
        count_d = 4'd0;
        last_d  = 3'd7;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      count_q <= 4'd0;
      last_q  <= 3'd7;   // channel 0 has first priority after reset
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign bus.oGrant = grant_q;
  assign bus.A      = sel_q[2];
  assign bus.B      = sel_q[1];
  assign bus.C      = sel_q[0];
  assign bus.oBusy  = busy_q;
  assign bus.oCount = count_q;

endmodule
